// File: rtl/dm_rr_arbiter_pkg.sv
// Shared definitions for the data-memory round-robin arbiter:
// FSM state encodings and default widths.
package dm_rr_arbiter_pkg;

    localparam int DEF_N_CORES = 4;
    localparam int DEF_AW      = 16;
    localparam int DEF_DW      = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/dm_rr_arbiter_rr_priority_pick.sv
// Combinational round-robin pick: rotate the request vector so that ptr sits at
// bit 0, priority-encode the lowest set bit, then rotate the index back.
module rr_priority_pick #(
    parameter int N  = 4,
    parameter int GW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [GW-1:0] ptr,
    output logic          valid,
    output logic [GW-1:0] idx
);

    logic [2*N-1:0] doubled;
    logic [N-1:0]   rotated;
    logic [GW-1:0]  enc;
    logic [GW:0]    sum;

    always_comb begin
        doubled = {req, req} >> ptr;
        rotated = doubled[N-1:0];
        enc     = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                enc = GW'(i);
            end
        end
        // Undo the rotation modulo N, which need not be a power of two.
        sum = {1'b0, enc} + {1'b0, ptr};
        if (sum >= (GW + 1)'(N)) begin
            sum = sum - (GW + 1)'(N);
        end
        idx   = sum[GW-1:0];
        valid = |req;
    end

endmodule

// File: rtl/dm_rr_arbiter.sv
// Round-robin arbiter sharing one synchronous single-port data memory among
// N cores; each transaction takes three cycles (IDLE -> ISSUE -> RESP).
module dm_rr_arbiter
    import dm_rr_arbiter_pkg::*;
#(
    parameter int N_CORES = DEF_N_CORES,
    parameter int AW      = DEF_AW,
    parameter int DW      = DEF_DW,
    parameter int GW      = $clog2(N_CORES)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_CORES-1:0]    core_req,
    input  logic [N_CORES-1:0]    core_we,
    input  logic [N_CORES*AW-1:0] core_addr,
    input  logic [N_CORES*DW-1:0] core_wdata,
    output logic [N_CORES-1:0]    core_ack,
    output logic [DW-1:0]         core_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [AW-1:0]         mem_addr,
    output logic [DW-1:0]         mem_wdata,
    input  logic [DW-1:0]         mem_rdata,
    output logic                  busy,
    output logic [GW-1:0]         grant_id
);

    arb_state_e state_q, state_d;

    logic [GW-1:0]      rrPtr_q, rrPtr_d;
    logic [GW-1:0]      grantId_q, grantId_d;
    logic               memEn_q, memEn_d;
    logic               memWe_q, memWe_d;
    logic [AW-1:0]      memAddr_q, memAddr_d;
    logic [DW-1:0]      memWdata_q, memWdata_d;
    logic [N_CORES-1:0] ack_q, ack_d;
    logic               respRead_q, respRead_d;
    logic               busy_q, busy_d;

    logic               pickValid;
    logic [GW-1:0]      pickIdx;
    logic [AW-1:0]      selAddr;
    logic [DW-1:0]      selWdata;
    logic               selWe;

    rr_priority_pick #(
        .N  (N_CORES),
        .GW (GW)
    ) u_pick (
        .req   (core_req),
        .ptr   (rrPtr_q),
        .valid (pickValid),
        .idx   (pickIdx)
    );

    always_comb begin
        selAddr  = '0;
        selWdata = '0;
        selWe    = 1'b0;
        for (int k = 0; k < N_CORES; k++) begin
            if (pickIdx == GW'(k)) begin
                selAddr  = core_addr[k*AW +: AW];
                selWdata = core_wdata[k*DW +: DW];
                selWe    = core_we[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (pickValid) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Address, data and grant hold between transactions; only mem_en qualifies them.
    always_comb begin
        rrPtr_d    = rrPtr_q;
        grantId_d  = grantId_q;
        memWe_d    = memWe_q;
        memAddr_d  = memAddr_q;
        memWdata_d = memWdata_q;
        memEn_d    = 1'b0;
        ack_d      = '0;
        respRead_d = 1'b0;
        busy_d     = (state_d != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (pickValid) begin
                    grantId_d  = pickIdx;
                    memAddr_d  = selAddr;
                    memWe_d    = selWe;
                    memWdata_d = selWdata;
                    memEn_d    = 1'b1;
                end
            end
            ST_ISSUE: begin
                for (int k = 0; k < N_CORES; k++) begin
                    ack_d[k] = (grantId_q == GW'(k));
                end
                respRead_d = ~memWe_q;
            end
            ST_RESP: begin
                rrPtr_d = (grantId_q == GW'(N_CORES - 1)) ? '0 : grantId_q + GW'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rrPtr_q    <= '0;
            grantId_q  <= '0;
            memEn_q    <= 1'b0;
            memWe_q    <= 1'b0;
            memAddr_q  <= '0;
            memWdata_q <= '0;
            ack_q      <= '0;
            respRead_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            rrPtr_q    <= rrPtr_d;
            grantId_q  <= grantId_d;
            memEn_q    <= memEn_d;
            memWe_q    <= memWe_d;
            memAddr_q  <= memAddr_d;
            memWdata_q <= memWdata_d;
            ack_q      <= ack_d;
            respRead_q <= respRead_d;
            busy_q     <= busy_d;
        end
    end

    // Memory read data only arrives in RESP, so it is gated by a registered
    // read flag rather than re-registered, keeping it aligned with the ack.
    assign core_rdata = respRead_q ? mem_rdata : '0;
    assign core_ack   = ack_q;
    assign mem_en     = memEn_q;
    assign mem_we     = memWe_q;
    assign mem_addr   = memAddr_q;
    assign mem_wdata  = memWdata_q;
    assign busy       = busy_q;
    assign grant_id   = grantId_q;

endmodule

// File: tb/tb_dm_rr_arbiter.sv
// Directed self-checking bench for dm_rr_arbiter with a synchronous
// one-cycle-read memory model and requesters that drop req on ack.
module tb_dm_rr_arbiter;

    localparam int N  = 4;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int GW = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      core_req;
    logic [N-1:0]      core_we;
    logic [N*AW-1:0]   core_addr;
    logic [N*DW-1:0]   core_wdata;
    logic [N-1:0]      core_ack;
    logic [DW-1:0]     core_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic [DW-1:0]     mem_rdata;
    logic              busy;
    logic [GW-1:0]     grant_id;

    logic [15:0]       mem [0:255];
    int                errors = 0;
    int                checks = 0;
    logic [N-1:0]      ackPrev;
    logic [N-1:0]      stickyMask;
    int                ackOrder [16];
    int                ackCycle [16];
    logic [DW-1:0]     ackData  [16];
    int                ackCount;

    dm_rr_arbiter #(
        .N_CORES (N),
        .AW      (AW),
        .DW      (DW),
        .GW      (GW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .core_req   (core_req),
        .core_we    (core_we),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_ack   (core_ack),
        .core_rdata (core_rdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .busy       (busy),
        .grant_id   (grant_id)
    );

    // Free-running clock, 10 ns period.
    always #5 clk = ~clk;

    // Synchronous single-port memory: access at the edge where mem_en is seen.
    initial begin
        for (int i = 0; i < 256; i++) mem[8'(i)] <= 16'h0000;
        mem[8'h10] <= 16'hBEEF;
        for (int k = 0; k < 4; k++) mem[8'(64 + k)] <= 16'hA000 + 16'(k);
        mem_rdata <= '0;
        forever begin
            @(posedge clk);
            if (mem_en) begin
                if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
                else        mem_rdata <= mem[mem_addr[7:0]];
            end
        end
    end

    // Watchdog so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int oneHotIdx(input logic [N-1:0] v);
        int r;
        r = -1;
        if ($countones(v) == 1) begin
            for (int i = 0; i < N; i++) if (v[i]) r = i;
        end
        return r;
    endfunction

    // Advance one clock; cores that saw ack drop req just after the edge.
    task automatic cycle();
        @(negedge clk);
        ackPrev = core_ack;
        @(posedge clk);
        #1;
        core_req = core_req & ~(ackPrev & ~stickyMask);
    endtask

    task automatic setCore(input int k, input logic we, input logic [15:0] addr, input logic [15:0] wd);
        core_we[k]              = we;
        core_addr[k*AW +: AW]   = addr;
        core_wdata[k*DW +: DW]  = wd;
        core_req[k]             = 1'b1;
    endtask

    // Run until nAcks acks are seen and everything is idle, recording order and timing.
    task automatic collectAcks(input int nAcks);
        int cyc;
        cyc      = 0;
        ackCount = 0;
        while (cyc < 60 && !(ackCount >= nAcks && core_req == '0 && busy == 1'b0)) begin
            cycle();
            cyc++;
            if (core_ack != '0 && ackCount < 16) begin
                ackOrder[ackCount] = oneHotIdx(core_ack);
                ackCycle[ackCount] = cyc;
                ackData[ackCount]  = core_rdata;
                ackCount++;
                if (ackCount >= nAcks) stickyMask = '0;
            end
        end
        checks++;
        if (cyc >= 60 || ackCount != nAcks) begin
            errors++;
            $display("[TB] FAIL collect_count: got %0d acks in %0d cycles, required %0d", ackCount, cyc, nAcks);
        end
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        core_req   = '0;
        core_we    = '0;
        core_addr  = '0;
        core_wdata = '0;
        stickyMask = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({core_ack, busy, mem_en, mem_we, grant_id} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got ack=%b busy=%b en=%b we=%b gid=%0d, required all 0",
                     core_ack, busy, mem_en, mem_we, grant_id);
        end
        checks++;
        if ({mem_addr, mem_wdata, core_rdata} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_data: got addr=%h wdata=%h rdata=%h, required 0", mem_addr, mem_wdata, core_rdata);
        end
        rst_n = 1'b1;
        cycle();
        cycle();
        checks++;
        if (busy !== 1'b0 || mem_en !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_no_req: got busy=%b en=%b, required 0 0", busy, mem_en);
        end
    endtask

    task automatic test_single_read();
        setCore(2, 1'b0, 16'h0010, 16'h0000);
        cycle();
        checks++;
        if ({mem_en, mem_we, mem_addr, grant_id, busy, core_ack} !== {1'b1, 1'b0, 16'h0010, 2'd2, 1'b1, 4'b0000}) begin
            errors++;
            $display("[TB] FAIL read_issue: got en=%b we=%b addr=%h gid=%0d busy=%b ack=%b, required 1 0 0010 2 1 0000",
                     mem_en, mem_we, mem_addr, grant_id, busy, core_ack);
        end
        cycle();
        checks++;
        if (core_ack !== 4'b0100 || core_rdata !== 16'hBEEF || mem_en !== 1'b0) begin
            errors++;
            $display("[TB] FAIL read_resp: got ack=%b rdata=%h en=%b, required 0100 beef 0", core_ack, core_rdata, mem_en);
        end
        cycle();
        checks++;
        if (core_ack !== 4'b0000 || busy !== 1'b0 || mem_addr !== 16'h0010 || core_rdata !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL read_after: got ack=%b busy=%b addr=%h rdata=%h, required 0000 0 0010 0000",
                     core_ack, busy, mem_addr, core_rdata);
        end
    endtask

    task automatic test_single_write();
        int pulses;
        setCore(1, 1'b1, 16'h0020, 16'h1234);
        cycle();
        pulses = int'(mem_en);
        checks++;
        if ({mem_en, mem_we, mem_addr, mem_wdata, grant_id} !== {1'b1, 1'b1, 16'h0020, 16'h1234, 2'd1}) begin
            errors++;
            $display("[TB] FAIL write_issue: got en=%b we=%b addr=%h wdata=%h gid=%0d, required 1 1 0020 1234 1",
                     mem_en, mem_we, mem_addr, mem_wdata, grant_id);
        end
        cycle();
        pulses += int'(mem_en);
        checks++;
        if (core_ack !== 4'b0010 || core_rdata !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL write_resp: got ack=%b rdata=%h, required 0010 0000", core_ack, core_rdata);
        end
        cycle();
        pulses += int'(mem_en);
        checks++;
        if (pulses != 1 || mem[8'h20] !== 16'h1234) begin
            errors++;
            $display("[TB] FAIL write_mem: got pulses=%0d mem[20]=%h, required 1 1234", pulses, mem[8'h20]);
        end
        setCore(3, 1'b0, 16'h0020, 16'h0000);
        cycle();
        cycle();
        checks++;
        if (core_ack !== 4'b1000 || core_rdata !== 16'h1234) begin
            errors++;
            $display("[TB] FAIL readback: got ack=%b rdata=%h, required 1000 1234", core_ack, core_rdata);
        end
        cycle();
    endtask

    task automatic test_midrun_reset();
        setCore(1, 1'b0, 16'h0041, 16'h0000);
        repeat (3) cycle();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({grant_id, mem_addr, busy, mem_en, core_ack} !== '0) begin
            errors++;
            $display("[TB] FAIL midrun_reset: got gid=%0d addr=%h busy=%b en=%b ack=%b, required all 0",
                     grant_id, mem_addr, busy, mem_en, core_ack);
        end
        core_req = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) setCore(k, 1'b0, 16'(64 + k), 16'h0000);
        collectAcks(4);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (ackOrder[k] != k || ackCycle[k] != 2 + 3 * k || ackData[k] !== 16'hA000 + 16'(k)) begin
                errors++;
                $display("[TB] FAIL all_four[%0d]: got core=%0d cycle=%0d data=%h, required core=%0d cycle=%0d data=%h",
                         k, ackOrder[k], ackCycle[k], ackData[k], k, 2 + 3 * k, 16'hA000 + 16'(k));
            end
        end
        setCore(1, 1'b0, 16'h0041, 16'h0000);
        setCore(3, 1'b0, 16'h0043, 16'h0000);
        collectAcks(2);
        checks++;
        if (ackOrder[0] != 1 || ackOrder[1] != 3 || ackCycle[0] != 2 || ackCycle[1] != 5) begin
            errors++;
            $display("[TB] FAIL pair_order: got %0d@%0d %0d@%0d, required 1@2 3@5",
                     ackOrder[0], ackCycle[0], ackOrder[1], ackCycle[1]);
        end
    endtask

    task automatic test_fairness();
        int expOrder [5];
        expOrder = '{0, 1, 2, 3, 0};
        stickyMask = 4'b0001;
        for (int k = 0; k < 4; k++) setCore(k, 1'b0, 16'(64 + k), 16'h0000);
        collectAcks(5);
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (ackOrder[k] != expOrder[k]) begin
                errors++;
                $display("[TB] FAIL fair_order[%0d]: got core=%0d, required core=%0d", k, ackOrder[k], expOrder[k]);
            end
        end
    endtask

    task automatic test_reset_during_issue();
        int seenAck;
        setCore(1, 1'b0, 16'h0041, 16'h0000);
        cycle();
        checks++;
        if (mem_en !== 1'b1 || grant_id !== 2'd1) begin
            errors++;
            $display("[TB] FAIL abort_issue: got en=%b gid=%0d, required 1 1", mem_en, grant_id);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({core_ack, mem_en, grant_id, busy} !== '0) begin
            errors++;
            $display("[TB] FAIL abort_reset: got ack=%b en=%b gid=%0d busy=%b, required all 0",
                     core_ack, mem_en, grant_id, busy);
        end
        core_req = '0;
        seenAck  = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (core_ack != '0) seenAck++;
        end
        rst_n = 1'b1;
        repeat (3) begin
            cycle();
            if (core_ack != '0) seenAck++;
        end
        checks++;
        if (seenAck != 0) begin
            errors++;
            $display("[TB] FAIL abort_no_ack: got %0d ack cycles, required 0", seenAck);
        end
        setCore(0, 1'b0, 16'h0040, 16'h0000);
        setCore(1, 1'b0, 16'h0041, 16'h0000);
        collectAcks(2);
        checks++;
        if (ackOrder[0] != 0 || ackOrder[1] != 1) begin
            errors++;
            $display("[TB] FAIL abort_ptr: got order %0d,%0d, required 0,1", ackOrder[0], ackOrder[1]);
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_single_write();
        test_midrun_reset();
        test_fairness();
        test_reset_during_issue();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
